// File: rtl/prog_loader_mt.sv
// prog_loader_mt: UART byte-stream program loader for several on-chip SRAMs.
// Parses framed records (SYNC,TGT,ADDR,LEN,data,CSUM), emits word writes,
// and holds the core in reset for the whole programming session.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   prog_i              level, enables a programming session
//   rx_dv_i, rx_byte_i  received byte strobe and value
//   we_o, tgt_sel_o     write strobe, one-hot target select
//   addr_o, wdata_o     word address and write data
//   hold_rst_o, busy_o  core reset hold, session active
//   done_o, err_o       session-complete pulse, sticky error
module prog_loader_mt #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned ADDR_WIDTH     = 12,
   parameter int unsigned NUM_TARGETS    = 2,
   parameter int unsigned TIMEOUT_CYCLES = 100000,
   parameter logic [7:0]  SYNC_BYTE      = 8'h5A
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   prog_i,
   input  logic                   rx_dv_i,
   input  logic [7:0]             rx_byte_i,
   output logic                   we_o,
   output logic [NUM_TARGETS-1:0] tgt_sel_o,
   output logic [ADDR_WIDTH-1:0]  addr_o,
   output logic [DATA_WIDTH-1:0]  wdata_o,
   output logic                   hold_rst_o,
   output logic                   busy_o,
   output logic                   done_o,
   output logic                   err_o
);

   localparam int unsigned B  = DATA_WIDTH / 8;
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

   typedef enum logic [3:0] {
      S_IDLE, S_SYNC, S_TGT, S_ADDR_LO, S_ADDR_HI,
      S_LEN_LO, S_LEN_HI, S_DATA, S_CSUM, S_DONE, S_ERR
   } state_e;

   state_e                 state_q, state_d;
   logic [2:0]             tgt_q, tgt_d;
   logic [15:0]            base_q, base_d;
   logic [15:0]            len_q, len_d;
   logic [15:0]            wcnt_q, wcnt_d;
   logic [2:0]             bcnt_q, bcnt_d;
   logic [DATA_WIDTH-1:0]  buf_q, buf_d;
   logic [7:0]             sum_q, sum_d;
   logic [TW-1:0]          tmo_q, tmo_d;
   logic                   we_q, we_d;
   logic [NUM_TARGETS-1:0] sel_q, sel_d;
   logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;
   logic                   hold_q, hold_d;
   logic                   busy_q, busy_d;
   logic                   done_q, done_d;
   logic                   err_q, err_d;

   logic [DATA_WIDTH-1:0]  word_w;
   logic                   timed_w;
   logic                   tmo_hit_w;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= S_IDLE;
         tgt_q   <= '0;
         base_q  <= '0;
         len_q   <= '0;
         wcnt_q  <= '0;
         bcnt_q  <= '0;
         buf_q   <= '0;
         sum_q   <= '0;
         tmo_q   <= '0;
         we_q    <= 1'b0;
         sel_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         hold_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         tgt_q   <= tgt_d;
         base_q  <= base_d;
         len_q   <= len_d;
         wcnt_q  <= wcnt_d;
         bcnt_q  <= bcnt_d;
         buf_q   <= buf_d;
         sum_q   <= sum_d;
         tmo_q   <= tmo_d;
         we_q    <= we_d;
         sel_q   <= sel_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         hold_q  <= hold_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      base_d  = base_q;
      len_d   = len_q;
      wcnt_d  = wcnt_q;
      bcnt_d  = bcnt_q;
      buf_d   = buf_q;
      sum_d   = sum_q;
      we_d    = 1'b0;
      sel_d   = sel_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      hold_d  = hold_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      err_d   = err_q;

      // Current word with the incoming byte dropped into its lane.
      word_w = buf_q;
      word_w[8*bcnt_q +: 8] = rx_byte_i;

      timed_w = (state_q == S_TGT)     || (state_q == S_ADDR_LO) ||
                (state_q == S_ADDR_HI) || (state_q == S_LEN_LO)  ||
                (state_q == S_LEN_HI)  || (state_q == S_DATA)    ||
                (state_q == S_CSUM);

      // Idle-cycle counter; only meaningful while inside a frame.
      tmo_d     = (rx_dv_i || !timed_w) ? '0 : tmo_q + 1'b1;
      tmo_hit_w = timed_w && !rx_dv_i &&
                  (tmo_q == TW'(TIMEOUT_CYCLES - 1));

      // Checksum covers TGT through the last data byte.
      if (rx_dv_i && timed_w && state_q != S_CSUM)
         sum_d = sum_q + rx_byte_i;

      unique case (state_q)
         S_IDLE: begin
            hold_d = 1'b0;
            busy_d = 1'b0;
            if (prog_i) begin
               state_d = S_SYNC;
               hold_d  = 1'b1;
               busy_d  = 1'b1;
               err_d   = 1'b0;
            end
         end
         S_DONE: begin
            if (!prog_i) state_d = S_IDLE;
         end
         S_ERR: begin
            if (!prog_i) begin
               state_d = S_IDLE;
               hold_d  = 1'b0;
            end
         end
         default: begin
            if (!prog_i) begin
               // Session withdrawn; any byte this cycle is dropped.
               state_d = S_IDLE;
               hold_d  = 1'b0;
               busy_d  = 1'b0;
               if (state_q != S_SYNC) err_d = 1'b1;
            end else if (rx_dv_i) begin
               unique case (state_q)
                  S_SYNC: begin
                     if (rx_byte_i == SYNC_BYTE) begin
                        state_d = S_TGT;
                        sum_d   = '0;
                     end
                  end
                  S_TGT: begin
                     if (rx_byte_i == 8'hFF) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        hold_d  = 1'b0;
                        busy_d  = 1'b0;
                     end else if (32'(rx_byte_i) < NUM_TARGETS) begin
                        tgt_d   = rx_byte_i[2:0];
                        state_d = S_ADDR_LO;
                     end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                     end
                  end
                  S_ADDR_LO: begin
                     base_d[7:0] = rx_byte_i;
                     state_d     = S_ADDR_HI;
                  end
                  S_ADDR_HI: begin
                     base_d[15:8] = rx_byte_i;
                     state_d      = S_LEN_LO;
                  end
                  S_LEN_LO: begin
                     len_d[7:0] = rx_byte_i;
                     state_d    = S_LEN_HI;
                  end
                  S_LEN_HI: begin
                     len_d[15:8] = rx_byte_i;
                     wcnt_d      = '0;
                     bcnt_d      = '0;
                     if ({rx_byte_i, len_q[7:0]} == 16'd0)
                        state_d = S_CSUM;
                     else
                        state_d = S_DATA;
                  end
                  S_DATA: begin
                     buf_d = word_w;
                     if (bcnt_q == 3'(B - 1)) begin
                        bcnt_d  = '0;
                        we_d    = 1'b1;
                        addr_d  = ADDR_WIDTH'(base_q + wcnt_q);
                        wdata_d = word_w;
                        sel_d   = NUM_TARGETS'(1) << tgt_q;
                        if (wcnt_q == len_q - 16'd1)
                           state_d = S_CSUM;
                        else
                           wcnt_d = wcnt_q + 16'd1;
                     end else begin
                        bcnt_d = bcnt_q + 3'd1;
                     end
                  end
                  S_CSUM: begin
                     if (rx_byte_i == sum_q) begin
                        state_d = S_SYNC;
                     end else begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                     end
                  end
                  default: ;
               endcase
            end else if (tmo_hit_w) begin
               state_d = S_ERR;
               err_d   = 1'b1;
               busy_d  = 1'b0;
            end
         end
      endcase
   end

   assign we_o       = we_q;
   assign tgt_sel_o  = sel_q;
   assign addr_o     = addr_q;
   assign wdata_o    = wdata_q;
   assign hold_rst_o = hold_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;

endmodule
